// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-wide little-endian memory, sub-word stores by read-modify-write.
// Optional macro LSU_MISALIGN_CHECK_EN rejects misaligned half/word requests with rsp_error instead of accessing memory.
module load_store_unit #(
    parameter logic [31:0] MEM_BASE = 32'h01000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_read_write
);

    // state  | meaning
    // IDLE   | ready for a request
    // LOAD   | read cycle for a load, data captured at end of cycle
    // RMW_RD | read cycle of a byte/half store, merge word captured
    // RMW_WR | write cycle of the merged word
    // WRITE  | write cycle of a full-word store
    // RESP   | one-cycle completion pulse
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_RMW_WR, S_WRITE, S_RESP} state_t;

    state_t      r_state;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_error;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_data_in;
    logic        r_mem_rw;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;

    logic        w_misalign;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merge;

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misalign = ((req_size == 2'b01) && req_addr[0]) || (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_byte = mem_data_out[7:0];
        case (r_lane)
            2'd1:    w_byte = mem_data_out[15:8];
            2'd2:    w_byte = mem_data_out[23:16];
            2'd3:    w_byte = mem_data_out[31:24];
            default: w_byte = mem_data_out[7:0];
        endcase
        w_half = r_lane[1] ? mem_data_out[31:16] : mem_data_out[15:0];
        case (r_size)
            2'b00:   w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
            default: w_load_data = mem_data_out;
        endcase
    end

    // Only the addressed lane is replaced; RMW is used for byte and half stores only.
    always_comb begin
        w_merge = mem_data_out;
        if (r_size == 2'b00) begin
            case (r_lane)
                2'd1:    w_merge[15:8]  = r_wdata[7:0];
                2'd2:    w_merge[23:16] = r_wdata[7:0];
                2'd3:    w_merge[31:24] = r_wdata[7:0];
                default: w_merge[7:0]   = r_wdata[7:0];
            endcase
        end else if (r_lane[1]) begin
            w_merge[31:16] = r_wdata;
        end else begin
            w_merge[15:0] = r_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 32'h0;
            r_rsp_error   <= 1'b0;
            r_mem_address <= MEM_BASE;
            r_mem_data_in <= 32'h0;
            r_mem_rw      <= 1'b0;
            r_size        <= 2'b00;
            r_unsigned    <= 1'b0;
            r_lane        <= 2'b00;
            r_wdata       <= 16'h0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_lane      <= req_addr[1:0];
                        r_wdata     <= req_wdata[15:0];
                        if (w_misalign) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 1'b1;
                            r_rsp_rdata <= 32'h0;
                            r_state     <= S_RESP;
                        end else begin
                            r_mem_address <= {req_addr[31:2], 2'b00};
                            if (!req_write) begin
                                r_state <= S_LOAD;
                            end else if (req_size[1]) begin
                                r_mem_data_in <= req_wdata;
                                r_mem_rw      <= 1'b1;
                                r_state       <= S_WRITE;
                            end else begin
                                r_state <= S_RMW_RD;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_error <= 1'b0;
                    r_rsp_rdata <= w_load_data;
                    r_state     <= S_RESP;
                end
                S_RMW_RD: begin
                    r_mem_data_in <= w_merge;
                    r_mem_rw      <= 1'b1;
                    r_state       <= S_RMW_WR;
                end
                S_RMW_WR, S_WRITE: begin
                    r_mem_rw    <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_error <= 1'b0;
                    r_rsp_rdata <= 32'h0;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_mem_rw    <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = r_req_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_error      = r_rsp_error;
    assign mem_address    = r_mem_address;
    assign mem_data_in    = r_mem_data_in;
    assign mem_read_write = r_mem_rw;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses, a negedge monitor pops and compares.
module tb_load_store_unit;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_read_write;

    load_store_unit #(.MEM_BASE(32'h01000000)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_read_write(mem_read_write)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word memory covering 0x01000000..0x010003FF
    logic [31:0] mem [0:255];
    logic        mem_load;
    assign mem_data_out = mem[mem_address[9:2]];
    always @(posedge clock) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h40] <= 32'h8badf00d;
        end else if (mem_read_write) begin
            mem[mem_address[9:2]] <= mem_data_in;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        longint      acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   wcount = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        longint lat;
        if (mem_read_write) wcount++;
        if (rsp_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual=1 expected=0");
            end else begin
                e = q.pop_front();
                lat = (longint'($time) - e.acc + 5) / 10;
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_error", {31'h0, rsp_error}, {31'h0, e.err});
                check("latency", 32'(lat), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] erd, input logic eerr, input int elat,
                         input logic keep, output int lows);
        exp_t e;
        int   n;
        lows = 0;
        n = 0;
        @(negedge clock);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        while (!req_ready && n < 20) begin
            lows++;
            n++;
            @(negedge clock);
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=0 expected=1");
        end
        e.rdata = erd; e.err = eerr; e.lat = elat;
        e.acc = longint'($time) + 5;
        q.push_back(e);
        if (!keep) begin
            @(negedge clock);
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d expected=0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int lows;
        int w0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        mem_load = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        mem_load = 1'b0;
        #1;
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_error", {31'h0, rsp_error}, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_rw", {31'h0, mem_read_write}, 32'h0);
        check("rst_address", mem_address, 32'h01000000);
        check("rst_data_in", mem_data_in, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Loads against 0x8badf00d
        w0 = wcount;
        issue(0, 2'b01, 1, 32'h01000102, 0, 32'h00008bad, 0, 2, 0, lows);
        issue(0, 2'b00, 0, 32'h01000100, 0, 32'h0000000d, 0, 2, 0, lows);
        issue(0, 2'b01, 0, 32'h01000102, 0, 32'hffff8bad, 0, 2, 0, lows);
        issue(0, 2'b00, 1, 32'h01000103, 0, 32'h0000008b, 0, 2, 0, lows);
        issue(0, 2'b00, 0, 32'h01000103, 0, 32'hffffff8b, 0, 2, 0, lows);
        issue(0, 2'b10, 0, 32'h01000100, 0, 32'h8badf00d, 0, 2, 0, lows);
        issue(0, 2'b11, 1, 32'h01000100, 0, 32'h8badf00d, 0, 2, 0, lows);
`ifdef LSU_MISALIGN_CHECK_EN
        issue(0, 2'b01, 1, 32'h01000101, 0, 32'h00000000, 1, 1, 0, lows);
        issue(0, 2'b10, 0, 32'h01000102, 0, 32'h00000000, 1, 1, 0, lows);
`else
        issue(0, 2'b01, 1, 32'h01000101, 0, 32'h0000f00d, 0, 2, 0, lows);
        issue(0, 2'b10, 0, 32'h01000102, 0, 32'h8badf00d, 0, 2, 0, lows);
`endif
        drain();
        check("loads_no_write", 32'(wcount - w0), 32'h0);

        // Stores
        w0 = wcount;
        issue(1, 2'b00, 0, 32'h01000101, 32'h0000005a, 32'h0, 0, 3, 0, lows);
        drain();
        check("sb_writes", 32'(wcount - w0), 32'h1);
        check("sb_word", mem[8'h40], 32'h8bad5a0d);
        issue(1, 2'b10, 0, 32'h01000104, 32'h12345678, 32'h0, 0, 2, 0, lows);
        drain();
        check("sw_word", mem[8'h41], 32'h12345678);
        issue(1, 2'b01, 0, 32'h01000106, 32'hffffabcd, 32'h0, 0, 3, 0, lows);
        drain();
        check("sh_word", mem[8'h41], 32'habcd5678);
        check("store_writes", 32'(wcount - w0), 32'h3);

        // Back-to-back loads with req_valid held high
        issue(0, 2'b10, 0, 32'h01000104, 0, 32'habcd5678, 0, 2, 1, lows);
        issue(0, 2'b00, 1, 32'h01000100, 0, 32'h0000000d, 0, 2, 0, lows);
        check("b2b_ready_low", 32'(lows), 32'h2);
        drain();

        // Reset during RMW_RD of a half store
        w0 = wcount;
        issue(0, 2'b01, 1, 32'h01000102, 0, 32'h00008bad, 0, 2, 0, lows);
        drain();
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h01000100; req_wdata = 32'h00001111;
        @(negedge clock);
        req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("abort_ready", {31'h0, req_ready}, 32'h1);
        check("abort_rw", {31'h0, mem_read_write}, 32'h0);
        check("abort_address", mem_address, 32'h01000000);
        check("abort_rdata", rsp_rdata, 32'h0);
        check("abort_data_in", mem_data_in, 32'h0);
        repeat (2) @(negedge clock);
        check("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("abort_writes", 32'(wcount - w0), 32'h0);
        check("abort_word", mem[8'h40], 32'h8bad5a0d);
        issue(0, 2'b10, 0, 32'h01000100, 0, 32'h8bad5a0d, 0, 2, 0, lows);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
